// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART message transmitter (sequencer states, frame length, ASCII codes).
// Latency: none; declarations only.
// Backpressure: none; UART_TX_PARITY_EN selects the 11-bit 8E1 frame instead of the 10-bit 8N1 frame.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } seq_state_t;

   localparam int FRAME_BITS_8N1 = 10;
   localparam int FRAME_BITS_8E1 = 11;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
   localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_GT = 8'h3E;
   localparam logic [7:0] PAD_BYTE = 8'h00;

   // 100 MHz core clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_byte.sv
// Purpose: serialise one byte as start, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop.
// Latency: TX goes low the cycle after byte_start; byte_done pulses in the last cycle of the stop bit.
// Backpressure: byte_start is ignored while byte_busy; the caller waits for byte_done.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       byte_start,
   input  logic [7:0] byte_data,
   output logic       TX,
   output logic       byte_busy,
   output logic       byte_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam int SH_W = FRAME_BITS - 1;
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   logic [CW-1:0]   baud_cnt;
   logic [3:0]      bit_idx;
   logic [SH_W-1:0] shift_q;
   logic [SH_W-1:0] frame_tail;
   logic            bit_end;

   // Everything after the start bit, LSB sent first; stop bit sits at the top.
   always_comb begin
`ifdef UART_TX_PARITY_EN
      frame_tail = {1'b1, ^byte_data, byte_data};
`else
      frame_tail = {1'b1, byte_data};
`endif
   end

   assign bit_end   = byte_busy && (baud_cnt == BAUD_LAST);
   assign byte_done = bit_end && (bit_idx == LAST_BIT);

   // Baud timing and bit shifting; TX is registered so reset forces it high at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         TX        <= 1'b1;
         byte_busy <= 1'b0;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_q   <= '0;
      end else if (!byte_busy) begin
         if (byte_start) begin
            TX        <= 1'b0;
            byte_busy <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_q   <= frame_tail;
         end
      end else if (bit_end) begin
         baud_cnt <= '0;
         if (bit_idx == LAST_BIT) begin
            byte_busy <= 1'b0;
            TX        <= 1'b1;
         end else begin
            TX      <= shift_q[0];
            shift_q <= {1'b0, shift_q[SH_W-1:1]};
            bit_idx <= bit_idx + 4'd1;
         end
      end else begin
         baud_cnt <= baud_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_msg_tx.sv
// Purpose: send a latched ASCII message over UART, first byte first, skipping 0x00 padding (parity via UART_TX_PARITY_EN).
// Latency: first start bit two cycles after MSG_VALID; one idle cycle between frames plus one per skipped byte.
// Backpressure: none upstream; MSG_VALID while BUSY is dropped and flagged by a one-cycle OVERRUN pulse.
module uart_msg_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int MSG_BYTES    = 10
)
(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [8*MSG_BYTES-1:0] MSG_IN,
   input  logic                   MSG_VALID,
   output logic                   TX,
   output logic                   BUSY,
   output logic                   MSG_DONE,
   output logic                   OVERRUN
);

   localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(MSG_BYTES - 1);

   seq_state_t             state_q;
   seq_state_t             state_d;
   logic [IW-1:0]          idx_q;
   logic [8*MSG_BYTES-1:0] buf_q;
   logic [7:0]             cur_byte;
   logic                   load;
   logic                   advance;
   logic                   byte_start;
   logic                   byte_busy;
   logic                   byte_done;
   logic                   overrun_q;

   // The buffer shifts left as bytes are consumed, so the current byte is always on top.
   assign cur_byte = buf_q[8*MSG_BYTES-1 -: 8];

   // Sequencer state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and control decode for the byte walk.
   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      advance    = 1'b0;
      byte_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (MSG_VALID) begin
               load    = 1'b1;
               state_d = SELECT;
            end
         end
         SELECT: begin
            if (cur_byte != PAD_BYTE) begin
               if (!byte_busy) begin
                  byte_start = 1'b1;
                  state_d    = WAIT;
               end
            end else if (idx_q == LAST_IDX) begin
               state_d = FINISH;
            end else begin
               advance = 1'b1;
            end
         end
         WAIT: begin
            if (byte_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = FINISH;
               end else begin
                  advance = 1'b1;
                  state_d = SELECT;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Message buffer and byte index; untouched by a dropped MSG_VALID.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         buf_q <= '0;
         idx_q <= '0;
      end else if (load) begin
         buf_q <= MSG_IN;
         idx_q <= '0;
      end else if (advance) begin
         buf_q <= buf_q << 8;
         idx_q <= idx_q + IW'(1);
      end
   end

   // Flag a message offered while the sequencer is anywhere but IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) overrun_q <= 1'b0;
      else     overrun_q <= MSG_VALID && (state_q != IDLE);
   end

   assign BUSY     = (state_q != IDLE);
   assign MSG_DONE = (state_q == FINISH);
   assign OVERRUN  = overrun_q;

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .CLK        (CLK),
      .RST        (RST),
      .byte_start (byte_start),
      .byte_data  (cur_byte),
      .TX         (TX),
      .byte_busy  (byte_busy),
      .byte_done  (byte_done)
   );

endmodule

// File: tb/tb_uart_msg_tx.sv
// Purpose: self-checking bench for uart_msg_tx; a serial monitor decodes TX frames against a byte queue.
// Latency: checks first start bit at k+2, MSG_DONE cycle, BUSY/OVERRUN pulse timing.
// Backpressure: exercises overrun during WAIT and FINISH, and reset mid-frame.
module tb_uart_msg_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int P = FB * CPB + 1;   // cycles from one start bit to the next

   localparam logic [79:0] M_OK  = {32'h4F4B0A3E, 48'h0};
   localparam logic [79:0] M_DB  = 80'h4445414442454546_0A3E;
   localparam logic [79:0] M_PAR = {16'h3130, 64'h0};

   logic        CLK;
   logic        RST;
   logic [79:0] MSG_IN;
   logic        MSG_VALID;
   logic        TX;
   logic        BUSY;
   logic        MSG_DONE;
   logic        OVERRUN;

   int         checks   = 0;
   int         failures = 0;
   int         done_cnt = 0;
   bit         mon_en   = 0;
   logic [7:0] exp_q[$];

   uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(10)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .MSG_IN    (MSG_IN),
      .MSG_VALID (MSG_VALID),
      .TX        (TX),
      .BUSY      (BUSY),
      .MSG_DONE  (MSG_DONE),
      .OVERRUN   (OVERRUN)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_bytes(input logic [79:0] m);
      logic [7:0] b;
      for (int i = 0; i < 10; i++) begin
         b = m[79-8*i -: 8];
         if (b != 8'h00) exp_q.push_back(b);
      end
   endtask

   // Drive MSG_VALID for one cycle; returns just after the sampling edge k.
   task automatic send_msg(input logic [79:0] m, input bit expect_tx);
      @(negedge CLK);
      MSG_IN    = m;
      MSG_VALID = 1'b1;
      if (expect_tx) push_bytes(m);
      @(posedge CLK);
      #1;
      MSG_VALID = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!MSG_DONE && cyc < budget);
      check_val("done_seen", MSG_DONE, 1);
   endtask

   // Decode one frame whose start bit was first seen this cycle.
   task automatic rx_frame();
      logic [7:0] d;
      logic [7:0] e;
      repeat (CPB / 2) @(negedge CLK);
      check_val("rx_start", TX, 0);
      for (int b = 0; b < 8; b++) begin
         repeat (CPB) @(negedge CLK);
         d[b] = TX;
      end
      check_val("rx_pending", exp_q.size() != 0, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check_val("rx_byte", d, e);
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge CLK);
      check_val("rx_parity", TX, ^e);
`endif
      repeat (CPB) @(negedge CLK);
      check_val("rx_stop", TX, 1);
      repeat (CPB - 1 - CPB / 2) @(negedge CLK);
   endtask

   initial begin : monitor
      forever begin
         @(negedge CLK);
         if (mon_en && !RST && TX == 1'b0) rx_frame();
      end
   end

   initial begin : done_counter
      forever begin
         @(negedge CLK);
         if (MSG_DONE === 1'b1) done_cnt++;
      end
   end

   initial begin : main
      int cyc;
      int d0;
      RST       = 1'b1;
      MSG_IN    = '0;
      MSG_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      check_val("rst_tx", TX, 1);
      check_val("rst_busy", BUSY, 0);
      check_val("rst_done", MSG_DONE, 0);
      check_val("rst_overrun", OVERRUN, 0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      mon_en = 1;

      // "OK\n>" with padding: start timing, gaps and trailing skip cycles
      send_msg(M_OK, 1);
      @(negedge CLK);
      check_val("t1_busy_k1", BUSY, 1);
      check_val("t1_tx_k1", TX, 1);
      @(negedge CLK);
      check_val("t1_tx_low_k2", TX, 0);
      wait_done(2000, cyc);
      check_val("t1_done_cycle", cyc + 2, 4 * P + 7);
      @(negedge CLK);
      check_val("t1_busy_after", BUSY, 0);

      // Ten non-zero bytes
      d0 = done_cnt;
      send_msg(M_DB, 1);
      wait_done(2000, cyc);
      check_val("t2_done_cycle", cyc, 10 * P + 1);
      check_val("t2_busy_at_done", BUSY, 1);
      @(negedge CLK);
      check_val("t2_busy_after", BUSY, 0);
      check_val("t2_done_low", MSG_DONE, 0);
      repeat (5) @(negedge CLK);
      check_val("t2_done_once", done_cnt - d0, 1);

      // All-zero message, then overrun offered in the FINISH cycle
      send_msg(80'h0, 1);
      for (int i = 1; i <= 11; i++) begin
         @(negedge CLK);
         check_val("t3_busy", BUSY, 1);
         check_val("t3_done", MSG_DONE, (i == 11) ? 1 : 0);
         check_val("t3_tx", TX, 1);
      end
      MSG_IN    = M_OK;
      MSG_VALID = 1'b1;
      @(posedge CLK);
      #1;
      MSG_VALID = 1'b0;
      @(negedge CLK);
      check_val("t3_ovr_finish", OVERRUN, 1);
      check_val("t3_busy_after", BUSY, 0);
      @(negedge CLK);
      check_val("t3_ovr_clear", OVERRUN, 0);
      repeat (10) @(negedge CLK);
      check_val("t3_tx_idle", TX, 1);

      // Second message 20 cycles into the first is dropped
      send_msg(M_OK, 1);
      repeat (19) @(negedge CLK);
      MSG_IN    = M_DB;
      MSG_VALID = 1'b1;
      @(posedge CLK);
      #1;
      MSG_VALID = 1'b0;
      MSG_IN    = '0;
      @(negedge CLK);
      check_val("t4_ovr_pulse", OVERRUN, 1);
      @(negedge CLK);
      check_val("t4_ovr_clear", OVERRUN, 0);
      wait_done(2000, cyc);
      check_val("t4_done_cycle", cyc + 21, 4 * P + 7);
      @(negedge CLK);

      // Reset in a data bit of byte 2 (0x0A, bit 4 = 0)
      mon_en = 0;
      send_msg(M_OK, 0);
      repeat (23 + 2 * P) @(negedge CLK);
      check_val("t5_tx_pre", TX, 0);
      d0 = done_cnt;
      #1;
      RST = 1'b1;
      #1;
      check_val("t5_tx_rst", TX, 1);
      check_val("t5_busy_rst", BUSY, 0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (20) @(negedge CLK);
      check_val("t5_no_done", done_cnt - d0, 0);
      mon_en = 1;
      send_msg(M_OK, 1);
      wait_done(2000, cyc);
      check_val("t5_done_cycle", cyc, 4 * P + 7);
      @(negedge CLK);

      // Parity-sensitive bytes 0x31 and 0x30
      send_msg(M_PAR, 1);
      wait_done(2000, cyc);
      check_val("t6_done_cycle", cyc, 2 * P + 9);
      repeat (5) @(negedge CLK);
      check_val("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
Downstream consumer of the UART message encoder. It takes the 80-bit, 10-byte ASCII message and its one-cycle completion strobe, then serialises the bytes MSB-byte-first onto a UART TX line (8N1, or 8E1 with parity enabled). Zero bytes are padding and are skipped, so short messages ("OK\n>", "FAIL\n>") send only their payload.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
MSG_BYTES, 10, bytes per message; MSG_IN width = 8*MSG_BYTES.

Ports:
CLK  input  1  system clock, all logic on posedge
RST  input  1  asynchronous, active-high reset
MSG_IN  input  80  message; byte i = MSG_IN[79-8i:72-8i], byte 0 sent first
MSG_VALID  input  1  one-cycle strobe: MSG_IN valid this cycle (encoder DONE)
TX  output  1  UART serial line, idle high
BUSY  output  1  message in progress; MSG_VALID not accepted
MSG_DONE  output  1  one-cycle pulse when the last byte is finished or skipped
OVERRUN  output  1  one-cycle pulse: MSG_VALID arrived while BUSY; that message is dropped

Behaviour:
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-high.
- Reset values: TX=1, BUSY=0, MSG_DONE=0, OVERRUN=0, state=IDLE, byte index=0, message buffer=0.
- Reset mid-frame: TX returns high immediately (asynchronously); the partial frame is abandoned with no MSG_DONE.
- Sequencer states: IDLE, SELECT, WAIT, FINISH.
- IDLE:
  - MSG_VALID at edge k latches MSG_IN and sets idx=0 → SELECT.
  - BUSY=1 from k+1.
- SELECT (1 cycle):
  - If byte[idx]!=0x00: pulse byte_start to the serialiser → WAIT.
  - Else if idx==MSG_BYTES-1 → FINISH.
  - Else idx++ and stay in SELECT.
  - Each skipped byte costs exactly 1 cycle.
- WAIT:
  - On byte_done, if idx==MSG_BYTES-1 → FINISH; else idx++ → SELECT.
- FINISH (1 cycle):
  - MSG_DONE=1 and BUSY=1 → IDLE.
  - BUSY=0 on the next cycle.
- Frame format: start bit (0), 8 data bits LSB first, optional parity, stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
- Timing:
  - A non-zero byte 0 drives TX low starting at cycle k+2.
  - byte_done asserts in the last cycle of the stop bit.
  - Consecutive sent bytes are therefore separated by exactly 1 extra idle-high cycle, plus 1 cycle per skipped byte between them.
- All-zero message: SELECT walks all 10 bytes, then FINISH; MSG_DONE at k+11, TX stays high.
- MSG_VALID while BUSY (SELECT, WAIT or FINISH): OVERRUN pulses the next cycle; buffer and state are unaffected.
- MSG_VALID in the same cycle as a FINISH pulse also counts as overrun.
- Internal zero bytes are skipped too; no escaping.
- Bit counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

Optional Feature:
UART_TX_PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit. The frame is 11 bits.
- Undefined: 8N1, 10-bit frame, and no parity logic is synthesised.
- Sequencer timing is unchanged apart from the frame length.

Decomposition:
- Shared package uart_pkg:
  - State enum for IDLE/SELECT/WAIT/FINISH.
  - Localparams for frame length (10/11), ASCII constants (0x0A, 0x3E), and default CLKS_PER_BIT.
- One sub-module, uart_tx_byte:
  - Ports: CLK, RST, byte_start, byte_data[7:0], TX, byte_busy, byte_done.
  - Contains the baud counter, bit counter, shift register and the parity option.
- uart_msg_tx contains the sequencer, message buffer and overrun logic.

Test Plan:
1. CLKS_PER_BIT=4; MSG_IN=0x4F4B0A3E followed by 48 zero bits; MSG_VALID pulse at k → bytes 4F,4B,0A,3E on TX; first TX low at k+2; 1-cycle gaps between frames; MSG_DONE after the 3E stop bit plus 6 skip cycles.
2. MSG_IN="DEADBEEF\n>" (0x4445414442454546_0A3E) → all 10 bytes sent in order, each decoded 8N1; MSG_DONE exactly once; BUSY low 1 cycle later.
3. MSG_IN=0 → TX never low; MSG_DONE at k+11; BUSY high k+1..k+11.
4. Second MSG_VALID 20 cycles into a message → OVERRUN pulse 1 cycle later; transmitted bytes match the first message only.
5. Assert RST mid-data-bit of byte 2 → TX=1, BUSY=0 immediately; no MSG_DONE. After release, a fresh message (0x4F4B0A3E…) is sent correctly.
6. With UART_TX_PARITY_EN defined, byte 0x31 → parity bit 1; byte 0x30 → parity bit 0; 11-bit frames.
